bomb_slot_scheduler: RTL and testbench

Central allocator and sequencer for the pool of bomb instances.
- Turns the player's drop key into a one-cycle arm pulse to the lowest free bomb slot, and latches the drop tile.
- Runs each slot's fuse (seconds) and blast (frames) lifetime, and accepts chain-detonation hits.
- Returns a slot to the pool only when its blast has finished, and reports bombs_left to the HUD.
- Sits between the keyboard/player logic and the bomb instances, replacing ad-hoc slot bookkeeping.

---
 rtl/bomb_slot_scheduler_if.sv | 32 +++
 rtl/bomb_slot_scheduler.sv | 149 ++++++++++++++
 tb/tb_bomb_slot_scheduler.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/bomb_slot_scheduler_if.sv
// Handshake bundle between keyboard/player logic, the slot scheduler and the bomb instances.
// The master side drives requests, timing pulses and chain hits; the slave side is the scheduler.
interface bomb_slot_scheduler_if #(
   parameter int NUM_SLOTS = 3
);
   logic                 OneSecPulse;
   logic                 startOfFrame;
   logic                 drop_bomb_key;
   logic [10:0]          player_topLeftX;
   logic [10:0]          player_topLeftY;
   logic                 capacity_up;
   logic [NUM_SLOTS-1:0] chain_hit;
   logic [NUM_SLOTS-1:0] slot_arm;
   logic [10:0]          drop_X;
   logic [10:0]          drop_Y;
   logic [NUM_SLOTS-1:0] explode;
   logic [NUM_SLOTS-1:0] blast_active;
   logic                 drop_denied;
   logic [3:0]           bombs_left;

   modport master (
      output OneSecPulse, startOfFrame, drop_bomb_key, player_topLeftX, player_topLeftY,
             capacity_up, chain_hit,
      input  slot_arm, drop_X, drop_Y, explode, blast_active, drop_denied, bombs_left
   );

   modport slave (
      input  OneSecPulse, startOfFrame, drop_bomb_key, player_topLeftX, player_topLeftY,
             capacity_up, chain_hit,
      output slot_arm, drop_X, drop_Y, explode, blast_active, drop_denied, bombs_left
   );
endinterface

// File: rtl/bomb_slot_scheduler.sv
// Allocates bomb slots on a drop-key edge and sequences each slot's fuse and blast lifetime.
// state    | meaning
// S_IDLE   | slot free, available for the next grant
// S_ARMED  | bomb placed, fuse counting OneSecPulse ticks down to detonation
// S_BLAST  | blast visible, frame counter counting startOfFrame ticks down to release
module bomb_slot_scheduler #(
   parameter int NUM_SLOTS      = 3,
   parameter int FUSE_SECONDS   = 3,
   parameter int BLAST_FRAMES   = 30,
   parameter int START_CAPACITY = 2,
   parameter int MAX_CAPACITY   = 3
) (
   input logic                  clk,
   input logic                  resetN,
   bomb_slot_scheduler_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_BLAST} slot_state_e;

   slot_state_e                state_q [NUM_SLOTS];
   slot_state_e                state_d [NUM_SLOTS];
   logic [NUM_SLOTS-1:0][3:0]  fuse_cnt_q, fuse_cnt_d;
   logic [NUM_SLOTS-1:0][5:0]  frame_cnt_q, frame_cnt_d;
   logic [NUM_SLOTS-1:0][10:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [10:0]                drop_x_q, drop_x_d, drop_y_q, drop_y_d;
   logic                       key_q, key_d;
   logic [NUM_SLOTS-1:0]       arm_q, arm_d, explode_q, explode_d;
   logic                       denied_q, denied_d;
   logic [3:0]                 cap_q, cap_d;

   logic [3:0]                 occ_cnt;
   logic                       pos_hit;
   logic                       idle_found;
   int                         free_idx;
   logic                       drop_req;
   logic                       grant_ok;
   logic [NUM_SLOTS-1:0]       blast_vec;

   // Grant conditions look only at registered state, so a slot freed on this edge waits a request.
   always_comb begin
      occ_cnt    = '0;
      pos_hit    = 1'b0;
      idle_found = 1'b0;
      free_idx   = 0;
      blast_vec  = '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
         if (state_q[i] != S_IDLE) occ_cnt = occ_cnt + 4'd1;
         if (state_q[i] == S_ARMED && pos_x_q[i] == bus.player_topLeftX &&
             pos_y_q[i] == bus.player_topLeftY) pos_hit = 1'b1;
         if (state_q[i] == S_IDLE && !idle_found) begin
            idle_found = 1'b1;
            free_idx   = i;
         end
         blast_vec[i] = (state_q[i] == S_BLAST);
      end
   end

   assign drop_req = bus.drop_bomb_key & ~key_q;
   assign grant_ok = (occ_cnt < cap_q) && idle_found && !pos_hit;

   always_comb begin
      state_d     = state_q;
      fuse_cnt_d  = fuse_cnt_q;
      frame_cnt_d = frame_cnt_q;
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      drop_x_d    = drop_x_q;
      drop_y_d    = drop_y_q;
      key_d       = bus.drop_bomb_key;
      arm_d       = '0;
      explode_d   = '0;
      denied_d    = 1'b0;
      cap_d       = cap_q;

      if (bus.capacity_up && cap_q < 4'(MAX_CAPACITY)) cap_d = cap_q + 4'd1;

      for (int i = 0; i < NUM_SLOTS; i++) begin
         case (state_q[i])
            S_ARMED: begin
               if (bus.chain_hit[i] || (bus.OneSecPulse && fuse_cnt_q[i] == 4'd1)) begin
                  state_d[i]     = S_BLAST;
                  explode_d[i]   = 1'b1;
                  frame_cnt_d[i] = 6'(BLAST_FRAMES);
               end else if (bus.OneSecPulse) begin
                  fuse_cnt_d[i] = fuse_cnt_q[i] - 4'd1;
               end
            end
            S_BLAST: begin
               if (bus.startOfFrame) begin
                  if (frame_cnt_q[i] == 6'd1) state_d[i] = S_IDLE;
                  else frame_cnt_d[i] = frame_cnt_q[i] - 6'd1;
               end
            end
            default: ;
         endcase
      end

      if (drop_req) begin
         if (grant_ok) begin
            state_d[free_idx]    = S_ARMED;
            fuse_cnt_d[free_idx] = 4'(FUSE_SECONDS);
            pos_x_d[free_idx]    = bus.player_topLeftX;
            pos_y_d[free_idx]    = bus.player_topLeftY;
            drop_x_d             = bus.player_topLeftX;
            drop_y_d             = bus.player_topLeftY;
            arm_d[free_idx]      = 1'b1;
         end else begin
            denied_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         for (int i = 0; i < NUM_SLOTS; i++) state_q[i] <= S_IDLE;
         fuse_cnt_q  <= '0;
         frame_cnt_q <= '0;
         pos_x_q     <= '0;
         pos_y_q     <= '0;
         drop_x_q    <= '0;
         drop_y_q    <= '0;
         key_q       <= 1'b0;
         arm_q       <= '0;
         explode_q   <= '0;
         denied_q    <= 1'b0;
         cap_q       <= 4'(START_CAPACITY);
      end else begin
         state_q     <= state_d;
         fuse_cnt_q  <= fuse_cnt_d;
         frame_cnt_q <= frame_cnt_d;
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         drop_x_q    <= drop_x_d;
         drop_y_q    <= drop_y_d;
         key_q       <= key_d;
         arm_q       <= arm_d;
         explode_q   <= explode_d;
         denied_q    <= denied_d;
         cap_q       <= cap_d;
      end
   end

   assign bus.slot_arm     = arm_q;
   assign bus.explode      = explode_q;
   assign bus.drop_denied  = denied_q;
   assign bus.drop_X       = drop_x_q;
   assign bus.drop_Y       = drop_y_q;
   assign bus.blast_active = blast_vec;
   assign bus.bombs_left   = (cap_q > occ_cnt) ? cap_q - occ_cnt : 4'd0;
endmodule

// File: tb/tb_bomb_slot_scheduler.sv
// Scoreboard bench for bomb_slot_scheduler: a lifetime model predicts per-edge events and status,
// a negedge monitor pops and compares them against what the scheduler presents.
module tb_bomb_slot_scheduler;
   localparam int NS    = 3;
   localparam int FUSE  = 3;
   localparam int BLAST = 30;
   localparam int START = 2;
   localparam int MAXC  = 3;

   logic clk = 1'b0;
   logic resetN = 1'b0;
   always #5 clk = ~clk;

   bomb_slot_scheduler_if #(.NUM_SLOTS(NS)) bus ();

   bomb_slot_scheduler #(
      .NUM_SLOTS(NS), .FUSE_SECONDS(FUSE), .BLAST_FRAMES(BLAST),
      .START_CAPACITY(START), .MAX_CAPACITY(MAXC)
   ) dut (
      .clk(clk), .resetN(resetN), .bus(bus)
   );

   typedef struct {
      int arm; int deny; int expl; int x; int y;
   } ev_t;
   typedef struct {
      int blast; int left; int x; int y;
   } st_t;

   ev_t ev_q[$];
   st_t st_q[$];
   int  n_checks = 0;
   int  n_fail   = 0;

   // Model: each slot tracks its phase and the ticks it has seen since entering that phase.
   int m_phase [NS];   // 0 free, 1 fused, 2 blasting
   int m_seen  [NS];
   int m_px    [NS];
   int m_py    [NS];
   int m_cap;
   int m_prev_key;
   int m_dx, m_dy;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic st_t model_status();
      st_t s;
      int busy;
      s.blast = 0;
      busy    = 0;
      for (int i = 0; i < NS; i++) begin
         if (m_phase[i] != 0) busy++;
         if (m_phase[i] == 2) s.blast |= (1 << i);
      end
      s.left = m_cap - busy;
      s.x    = m_dx;
      s.y    = m_dy;
      return s;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_phase[i] = 0; m_seen[i] = 0; m_px[i] = 0; m_py[i] = 0;
      end
      m_cap = START; m_prev_key = 0; m_dx = 0; m_dy = 0;
   endtask

   task automatic model_step(input int key, input int px, input int py, input int sec,
                             input int sof, input int cup, input int ch);
      ev_t e;
      int  req, busy, clash, first_free;
      e = '{default: 0};
      req = (key != 0 && m_prev_key == 0) ? 1 : 0;
      m_prev_key = key;
      busy = 0; clash = 0; first_free = -1;
      for (int i = 0; i < NS; i++) begin
         if (m_phase[i] != 0) busy++;
         if (m_phase[i] == 1 && m_px[i] == px && m_py[i] == py) clash = 1;
         if (m_phase[i] == 0 && first_free < 0) first_free = i;
      end
      for (int i = 0; i < NS; i++) begin
         if (m_phase[i] == 1) begin
            if (sec != 0) m_seen[i]++;
            if (((ch >> i) & 1) != 0 || m_seen[i] == FUSE) begin
               m_phase[i] = 2; m_seen[i] = 0; e.expl |= (1 << i);
            end
         end else if (m_phase[i] == 2) begin
            if (sof != 0) m_seen[i]++;
            if (m_seen[i] == BLAST) m_phase[i] = 0;
         end
      end
      if (req != 0) begin
         if (busy < m_cap && first_free >= 0 && clash == 0) begin
            m_phase[first_free] = 1; m_seen[first_free] = 0;
            m_px[first_free] = px; m_py[first_free] = py;
            m_dx = px; m_dy = py;
            e.arm = 1 << first_free; e.x = px; e.y = py;
         end else begin
            e.deny = 1;
         end
      end
      if (cup != 0 && m_cap < MAXC) m_cap++;
      if (e.arm != 0 || e.deny != 0 || e.expl != 0) ev_q.push_back(e);
      st_q.push_back(model_status());
   endtask

   task automatic cycle(input int key, input int px, input int py, input int sec,
                        input int sof, input int cup, input int ch);
      @(negedge clk); #1;
      resetN                 = 1'b1;
      bus.drop_bomb_key      = key[0];
      bus.player_topLeftX    = 11'(px);
      bus.player_topLeftY    = 11'(py);
      bus.OneSecPulse        = sec[0];
      bus.startOfFrame       = sof[0];
      bus.capacity_up        = cup[0];
      bus.chain_hit          = NS'(ch);
      model_step(key, px, py, sec, sof, cup, ch);
   endtask

   task automatic do_reset();
      @(negedge clk); #1;
      resetN = 1'b0;
      bus.drop_bomb_key = 1'b0; bus.OneSecPulse = 1'b0; bus.startOfFrame = 1'b0;
      bus.capacity_up = 1'b0; bus.chain_hit = '0;
      model_reset();
      ev_q.delete();
      #1;
      chk("rst_slot_arm", int'(bus.slot_arm), 0);
      chk("rst_explode", int'(bus.explode), 0);
      chk("rst_blast_active", int'(bus.blast_active), 0);
      chk("rst_drop_denied", int'(bus.drop_denied), 0);
      chk("rst_drop_X", int'(bus.drop_X), 0);
      chk("rst_drop_Y", int'(bus.drop_Y), 0);
      chk("rst_bombs_left", int'(bus.bombs_left), START);
      st_q.push_back(model_status());
   endtask

   task automatic drop(input int px, input int py);
      cycle(1, px, py, 0, 0, 0, 0);
      cycle(0, px, py, 0, 0, 0, 0);
      cycle(0, px, py, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      st_t s;
      ev_t e;
      if (st_q.size() > 0) begin
         s = st_q.pop_front();
         chk("blast_active", int'(bus.blast_active), s.blast);
         chk("bombs_left", int'(bus.bombs_left), s.left);
         chk("drop_X", int'(bus.drop_X), s.x);
         chk("drop_Y", int'(bus.drop_Y), s.y);
      end
      if (bus.slot_arm != '0 || bus.drop_denied || bus.explode != '0) begin
         if (ev_q.size() == 0) begin
            chk("unexpected_event", 1, 0);
         end else begin
            e = ev_q.pop_front();
            chk("slot_arm", int'(bus.slot_arm), e.arm);
            chk("drop_denied", int'(bus.drop_denied), e.deny);
            chk("explode", int'(bus.explode), e.expl);
         end
      end
   end

   initial begin
      int key, px, py, pick;
      bus.drop_bomb_key = 1'b0; bus.OneSecPulse = 1'b0; bus.startOfFrame = 1'b0;
      bus.capacity_up = 1'b0; bus.chain_hit = '0;
      bus.player_topLeftX = '0; bus.player_topLeftY = '0;
      model_reset();

      do_reset();
      for (int i = 0; i < 10; i++) cycle(1, 64, 96, 0, 0, 0, 0);
      cycle(0, 64, 96, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 64, 96, 1, 0, 0, 0);
         cycle(0, 64, 96, 0, 0, 0, 0);
      end
      for (int i = 0; i < 32; i++) cycle(0, 64, 96, 0, 1, 0, 0);

      do_reset();
      drop(64, 96);
      drop(128, 96);
      drop(200, 40);
      cycle(0, 0, 0, 0, 0, 1, 0);
      drop(200, 40);
      drop(300, 300);
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 25; i++) cycle(0, 0, 0, 0, 1, 0, 0);
      do_reset();

      drop(64, 96);
      drop(64, 96);
      drop(128, 96);
      cycle(0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 2);
      cycle(0, 0, 0, 1, 0, 0, 0);
      cycle(0, 0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 35; i++) cycle(0, 0, 0, 0, 1, 0, 0);

      key = 0;
      for (int n = 0; n < 6000; n++) begin
         if ($urandom_range(0, 1499) == 0) begin
            do_reset();
            key = 0;
         end else begin
            if ($urandom_range(0, 3) == 0) key = 1 - key;
            pick = int'($urandom_range(0, 3));
            px = (pick == 1 || pick == 3) ? 128 : 64;
            py = (pick >= 2) ? 160 : 96;
            cycle(key, px, py,
                  ($urandom_range(0, 24) == 0) ? 1 : 0,
                  ($urandom_range(0, 3) == 0) ? 1 : 0,
                  ($urandom_range(0, 399) == 0) ? 1 : 0,
                  (($urandom_range(0, 79) == 0) ? 1 : 0) |
                  (($urandom_range(0, 79) == 0) ? 2 : 0) |
                  (($urandom_range(0, 79) == 0) ? 4 : 0));
         end
      end

      @(negedge clk);
      @(negedge clk);
      #1;
      chk("events_pending", ev_q.size(), 0);
      chk("status_pending", st_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
